alu_li_issue_queue: RTL
=======================

Name: alu_li_issue_queue

Overview:
- Ready/valid operand issue queue that sits directly upstream of the latency-insensitive ALU (ALU_LI) and feeds it.
- Buffers up to DEPTH {op, a, b} transactions from a producer, such as a bench driver or a decode stage, and presents them in order to the ALU_LI input handshake.
- Stamps each accepted transaction with a wrapping sequence tag, so downstream checkers can pair each ALU_LI result with the operands that produced it.

Parameters:
- WIDTH, 32, operand width in bits (a, b).
- DEPTH, 4, number of queue entries; power of two, at least 2.
- TAG_W, 8, width of the sequence tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_in  in  WIDTH  producer operand A.
- b_in  in  WIDTH  producer operand B.
- op_in  in  1  producer opcode bit.
- valid_in  in  1  producer transaction valid.
- ready_out  out  1  queue can accept a transaction.
- a_out  out  WIDTH  head operand A; connects to ALU_LI a_in.
- b_out  out  WIDTH  head operand B; connects to ALU_LI b_in.
- op_out  out  1  head opcode; connects to ALU_LI op_in.
- tag_out  out  TAG_W  sequence tag of the head entry.
- valid_out  out  1  head entry valid; connects to ALU_LI valid_in.
- ready_in  in  1  consumer ready; driven by ALU_LI ready_out.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset
  - Reset is asynchronous and active-high.
  - It clears the read pointer, write pointer, count and tag counter to 0.
  - While reset is high: valid_out=0, ready_out=0, count=0.
  - Data outputs are 0 while reset is high.
  - Entry storage is not reset.
  - On the first rising edge after reset is released, ready_out=1.
- Handshake definitions
  - push = valid_in & ready_out.
  - pop = valid_out & ready_in.
  - A transfer happens only on a rising edge where the handshake condition is true.
- Flow-control outputs
  - ready_out = (count != DEPTH) & !reset. It is registered and has no combinational path from ready_in.
  - valid_out = (count != 0).
  - Head outputs a_out, b_out, op_out and tag_out come from the entry at the read pointer.
  - All head outputs are forced to 0 when valid_out=0.
- Stability
  - While valid_out=1 and ready_in=0, the head outputs hold stable cycle to cycle.
- Latency
  - A push into an empty queue appears at valid_out on the next cycle (1-cycle latency).
- Ordering
  - Strict FIFO order; no reordering and no drops.
- Tags
  - Each push writes the entry with tag = tag counter, then the tag counter increments.
  - The tag counter wraps modulo 2^TAG_W: 2^TAG_W-1 is followed by 0.
- Pointers
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - count tracks occupancy.
- Count update
  - push without pop: count+1.
  - pop without push: count-1.
  - push and pop in the same cycle: count unchanged, both pointers advance.
- Full
  - ready_out=0, so no push can occur.
  - A pop while full raises ready_out on the next cycle.
- Empty
  - valid_out=0, so ready_in is ignored and no pop occurs.
- Reset mid-operation
  - All queued entries are discarded immediately and asynchronously.
  - valid_out drops without waiting for a clock edge.
  - The tag counter restarts at 0.
- Producer rule
  - The producer must hold its data stable while valid_in=1 and ready_out=0.
  - The queue does not check this rule.

Optional Feature:
- Macro: ALU_LI_ISSUE_Q_BYPASS_EN.
- When defined, an empty queue passes a transaction straight through in the same cycle:
  - When count==0: valid_out=valid_in, and head outputs = a_in, b_in, op_in, tag counter.
  - If ready_in is also 1, the transfer completes without writing storage.
  - The tag counter still increments and count stays 0.
  - If ready_in=0 in that cycle, the transaction is stored normally through the push path.
  - ready_out is unchanged: !full, with no path from ready_in.
- When undefined: the 1-cycle minimum latency described above applies.

Test Plan:
- Reset then single push: push a=0x3F800000, b=0x40000000, op=1 with ready_in=1 -> next cycle valid_out=1 with the same values and tag_out=0; following cycle valid_out=0, count=0.
- Fill and backpressure: ready_in=0, push 5 transactions with a=1..5 at DEPTH=4 -> count=4, ready_out=0 after the 4th push, the 5th is held by the producer; then ready_in=1 -> pops with a=1,2,3,4,5 in order, tags 0..4.
- Full simultaneous push/pop: queue at count=3, push and pop in the same cycle -> count stays 3; a further push reaches count=4; pop order preserved.
- Tag wrap: TAG_W=8, 257 push/pop pairs -> transaction 256 has tag_out=0x00, transaction 255 has 0xFF.
- Mid-operation reset: count=3 with ready_in=0, assert reset between edges -> valid_out=0 and count=0 immediately; after release, a new push gets tag_out=0.
- ALU_LI chain: issue queue feeding ALU_LI with random ready stalls, 1000 random a/b/op -> ALU_LI results match the static ALU in tag order, with zero mismatches; with bypass enabled, an empty-queue push with ready_in=1 shows valid_out=1 in the same cycle.

Source files
------------

// File: rtl/alu_li_issue_queue_if.sv
// Handshake bundle between a producer, alu_li_issue_queue and the ALU_LI input side.
interface alu_li_issue_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             op_in;
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             op_out;
    logic [TAG_W-1:0] tag_out;
    logic             valid_out;
    logic             ready_in;
    logic [CW-1:0]    count;

    modport slave (
        input  a_in, b_in, op_in, valid_in, ready_in,
        output ready_out, a_out, b_out, op_out, tag_out, valid_out, count
    );

    modport master (
        output a_in, b_in, op_in, valid_in, ready_in,
        input  ready_out, a_out, b_out, op_out, tag_out, valid_out, count
    );
endinterface

// File: rtl/alu_li_issue_queue.sv
// Tagged in-order operand queue feeding ALU_LI; ALU_LI_ISSUE_Q_BYPASS_EN enables
// same-cycle pass-through of a transaction when the queue is empty.
module alu_li_issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_li_issue_queue_if.slave   q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_PTR  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] ONE_TAG  = {{(TAG_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_a_r   [DEPTH];
    logic [WIDTH-1:0] mem_b_r   [DEPTH];
    logic             mem_op_r  [DEPTH];
    logic [TAG_W-1:0] mem_tag_r [DEPTH];

    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [TAG_W-1:0] tag_r;
    logic             ready_r;

    logic             push_s;
    logic             write_s;
    logic             pop_stored_s;
    logic             stored_valid_s;
    logic             valid_s;

    logic [WIDTH-1:0] head_a_s;
    logic [WIDTH-1:0] head_b_s;
    logic             head_op_s;
    logic [TAG_W-1:0] head_tag_s;

    assign push_s         = q.valid_in & ready_r;
    assign stored_valid_s = (count_r != {CW{1'b0}});
    assign pop_stored_s   = stored_valid_s & q.ready_in;

`ifdef ALU_LI_ISSUE_Q_BYPASS_EN
    // An empty queue offers the incoming transaction directly; if taken, nothing is stored.
    assign valid_s = stored_valid_s | push_s;
    assign write_s = push_s & ~(~stored_valid_s & q.ready_in);
`else
    assign valid_s = stored_valid_s;
    assign write_s = push_s;
`endif

    // Occupancy after this edge.
    always_comb begin
        count_next_s = count_r;
        if (write_s && !pop_stored_s) begin
            count_next_s = count_r + ONE_CNT;
        end else if (!write_s && pop_stored_s) begin
            count_next_s = count_r - ONE_CNT;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy, tag counter and the registered ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            tag_r    <= {TAG_W{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_stored_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            if (push_s) begin
                tag_r <= tag_r + ONE_TAG;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != FULL_CNT);
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_a_r[wr_ptr_r]   <= q.a_in;
            mem_b_r[wr_ptr_r]   <= q.b_in;
            mem_op_r[wr_ptr_r]  <= q.op_in;
            mem_tag_r[wr_ptr_r] <= tag_r;
        end
    end

    // Head selection, zeroed whenever nothing is offered downstream.
    always_comb begin
        head_a_s   = {WIDTH{1'b0}};
        head_b_s   = {WIDTH{1'b0}};
        head_op_s  = 1'b0;
        head_tag_s = {TAG_W{1'b0}};
        if (stored_valid_s) begin
            head_a_s   = mem_a_r[rd_ptr_r];
            head_b_s   = mem_b_r[rd_ptr_r];
            head_op_s  = mem_op_r[rd_ptr_r];
            head_tag_s = mem_tag_r[rd_ptr_r];
`ifdef ALU_LI_ISSUE_Q_BYPASS_EN
        end else if (valid_s) begin
            head_a_s   = q.a_in;
            head_b_s   = q.b_in;
            head_op_s  = q.op_in;
            head_tag_s = tag_r;
`endif
        end else begin
            head_a_s   = {WIDTH{1'b0}};
            head_b_s   = {WIDTH{1'b0}};
            head_op_s  = 1'b0;
            head_tag_s = {TAG_W{1'b0}};
        end
    end

    assign q.ready_out = ready_r;
    assign q.valid_out = valid_s;
    assign q.count     = count_r;
    assign q.a_out     = head_a_s;
    assign q.b_out     = head_b_s;
    assign q.op_out    = head_op_s;
    assign q.tag_out   = head_tag_s;
endmodule
